// File: rtl/free_list_ctrl_if.sv
// Purpose: rename/commit side bundle of the physical register free list.
// Latency: free_idx/pop_ready are combinational views of registered state; count is registered.
// Backpressure: pop_ready is all-or-nothing for every rename lane; pushes are never stalled.
interface free_list_ctrl_if #(
    parameter int PRF_DEPTH = 64,
    parameter int ARF_DEPTH = 32,
    parameter int ID_WIDTH  = 2,
    parameter int CM_WIDTH  = 2
);
    localparam int PRF_IDX = $clog2(PRF_DEPTH);
    localparam int N       = PRF_DEPTH - ARF_DEPTH;
    localparam int PTR     = $clog2(N) + 1;

    logic [ID_WIDTH-1:0]               pop_valid;
    logic                              pop_ready;
    logic [ID_WIDTH-1:0][PRF_IDX-1:0]  free_idx;
    logic [CM_WIDTH-1:0]               push_valid;
    logic [CM_WIDTH-1:0][PRF_IDX-1:0]  push_idx;
    logic [CM_WIDTH-1:0]               commit_alloc;
    logic                              flush;
    logic [PTR-1:0]                    count;

    // Requester side: rename lanes, commit path and flush source.
    modport master (
        output pop_valid, push_valid, push_idx, commit_alloc, flush,
        input  pop_ready, free_idx, count
    );

    // Free list controller side.
    modport slave (
        input  pop_valid, push_valid, push_idx, commit_alloc, flush,
        output pop_ready, free_idx, count
    );
endinterface

// File: rtl/free_list_ctrl.sv
// Purpose: circular free list of physical register indices with flush rollback to the committed head.
// Latency: free_idx is read combinationally from mem[head]; pushes become visible the cycle after.
// Backpressure: pop_ready drops when fewer than ID_WIDTH entries are free or during flush.
module free_list_ctrl #(
    parameter int PRF_DEPTH = 64,
    parameter int ARF_DEPTH = 32,
    parameter int ID_WIDTH  = 2,
    parameter int CM_WIDTH  = 2
) (
    input  logic            clk,
    input  logic            rst,
    free_list_ctrl_if.slave fl
);
    localparam int PRF_IDX = $clog2(PRF_DEPTH);
    // N must be a power of two so pointer arithmetic wraps naturally.
    localparam int N       = PRF_DEPTH - ARF_DEPTH;
    localparam int IDXW    = $clog2(N);
    localparam int PTR     = IDXW + 1;

    typedef logic [PTR-1:0]     ptr_t;
    typedef logic [IDXW-1:0]    idx_t;
    typedef logic [PRF_IDX-1:0] preg_t;

    preg_t mem_q [N];
    preg_t mem_d [N];
    ptr_t  head_q, head_d;
    ptr_t  tail_q, tail_d;
    ptr_t  cm_head_q, cm_head_d;
    ptr_t  count_q, count_d;

    logic  pop_ready;
    ptr_t  pop_cnt;
    ptr_t  push_cnt;
    ptr_t  ca_cnt;
    idx_t  rd_off;
    idx_t  rd_idx;
    idx_t  wr_idx;

    // Rename-side view: lane i skips the entries claimed by lower valid lanes.
    always_comb begin
        pop_ready   = (count_q >= ptr_t'(ID_WIDTH)) && !fl.flush;
        rd_off      = '0;
        rd_idx      = '0;
        fl.free_idx = '0;
        for (int i = 0; i < ID_WIDTH; i++) begin
            rd_idx         = head_q[IDXW-1:0] + rd_off;
            fl.free_idx[i] = mem_q[rd_idx];
            rd_off         = rd_off + idx_t'(fl.pop_valid[i]);
        end
        fl.pop_ready = pop_ready;
        fl.count     = count_q;
    end

    // Next-state: compacted pushes at tail, pops or flush rollback at head, commit tracking.
    always_comb begin
        mem_d    = mem_q;
        pop_cnt  = '0;
        push_cnt = '0;
        ca_cnt   = '0;
        wr_idx   = '0;
        for (int i = 0; i < ID_WIDTH; i++) begin
            pop_cnt = pop_cnt + ptr_t'(fl.pop_valid[i]);
        end
        for (int i = 0; i < CM_WIDTH; i++) begin
            if (fl.push_valid[i]) begin
                wr_idx        = tail_q[IDXW-1:0] + push_cnt[IDXW-1:0];
                mem_d[wr_idx] = fl.push_idx[i];
                push_cnt      = push_cnt + ptr_t'(1);
            end
            ca_cnt = ca_cnt + ptr_t'(fl.commit_alloc[i]);
        end
        tail_d    = tail_q + push_cnt;
        cm_head_d = cm_head_q + ca_cnt;
        if (fl.flush) begin
            // Everything allocated past the committed head is reclaimed at once.
            head_d = cm_head_d;
        end else if (pop_ready && (|fl.pop_valid)) begin
            head_d = head_q + pop_cnt;
        end else begin
            head_d = head_q;
        end
        count_d = tail_d - head_d;
    end

    // State registers; reset maps phys ARF_DEPTH.. as the initial free pool.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q    <= '0;
            tail_q    <= ptr_t'(N);
            cm_head_q <= '0;
            count_q   <= ptr_t'(N);
            for (int k = 0; k < N; k++) begin
                mem_q[k] <= preg_t'(ARF_DEPTH + k);
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            cm_head_q <= cm_head_d;
            count_q   <= count_d;
            mem_q     <= mem_d;
        end
    end

    // Input contract checks; the datapath itself does not guard against these.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (|fl.push_valid) begin
                assert (count_d <= ptr_t'(N));
            end
            for (int i = 0; i < CM_WIDTH; i++) begin
                if (fl.push_valid[i]) begin
                    assert (fl.push_idx[i] != '0);
                end
            end
            assert (ptr_t'(head_d - cm_head_d) <= ptr_t'(N));
            assert (ca_cnt <= push_cnt);
        end
    end
endmodule

// File: tb/tb_free_list_ctrl.sv
// Purpose: directed bench for free_list_ctrl with a per-cycle reference model.
// Latency: outputs compared each falling edge; directed checks 1 time unit after stimulus.
// Backpressure: stimulus pops only while the model reports room, except where blocking is tested.
module tb_free_list_ctrl;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    free_list_ctrl_if #(.PRF_DEPTH(64), .ARF_DEPTH(32), .ID_WIDTH(2), .CM_WIDTH(2)) bus ();

    free_list_ctrl #(.PRF_DEPTH(64), .ARF_DEPTH(32), .ID_WIDTH(2), .CM_WIDTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .fl  (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: a ring of N slots addressed by unbounded integer positions.
    int m_mem [N];
    int m_head;
    int m_tail;
    int m_cm;
    bit m_valid = 1'b0;

    function automatic int pc2(input logic [1:0] v);
        return int'(v[0]) + int'(v[1]);
    endfunction

    function automatic int m_count();
        return m_tail - m_head;
    endfunction

    function automatic bit m_ready();
        return (m_count() >= 2) && !bus.flush;
    endfunction

    always @(posedge clk) begin
        int ca;
        int j;
        bit rdy;
        if (!rst) begin
            for (int k = 0; k < N; k++) m_mem[k] = 32 + k;
            m_head  = 0;
            m_tail  = N;
            m_cm    = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            rdy = m_ready();
            ca  = pc2(bus.commit_alloc);
            j   = 0;
            for (int i = 0; i < 2; i++) begin
                if (bus.push_valid[i]) begin
                    m_mem[(m_tail + j) % N] = int'(bus.push_idx[i]);
                    j++;
                end
            end
            if (bus.flush) m_head = m_cm + ca;
            else if (rdy) m_head = m_head + pc2(bus.pop_valid);
            m_tail = m_tail + j;
            m_cm   = m_cm + ca;
        end
    end

    // Single compare process against the model.
    always @(negedge clk) begin
        if (rst && m_valid) begin
            chk("cyc_count", int'(bus.count), m_count());
            chk("cyc_pop_ready", int'(bus.pop_ready), int'(m_ready()));
            if (m_ready()) begin
                chk("cyc_free_idx0", int'(bus.free_idx[0]), m_mem[m_head % N]);
                chk("cyc_free_idx1", int'(bus.free_idx[1]),
                    m_mem[(m_head + int'(bus.pop_valid[0])) % N]);
            end
        end
    end

    task automatic drive(input logic [1:0] pv, input logic [1:0] psv, input int i0, input int i1,
                         input logic [1:0] ca, input logic fl);
        bus.pop_valid    = pv;
        bus.push_valid   = psv;
        bus.push_idx[0]  = 6'(i0);
        bus.push_idx[1]  = 6'(i1);
        bus.commit_alloc = ca;
        bus.flush        = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(2'b00, 2'b00, 1, 1, 2'b00, 1'b0);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int e0;
        int e1;

        // Reset image and first pops.
        do_reset();
        drive(2'b11, 2'b00, 1, 1, 2'b00, 1'b0);
        chk("rst_count", int'(bus.count), 32);
        chk("rst_pop_ready", int'(bus.pop_ready), 1);
        chk("rst_free_idx0", int'(bus.free_idx[0]), 32);
        chk("rst_free_idx1", int'(bus.free_idx[1]), 33);
        tick();
        drive(2'b10, 2'b00, 1, 1, 2'b00, 1'b0);
        chk("dual_pop_count", int'(bus.count), 30);
        chk("lane1_only_free_idx1", int'(bus.free_idx[1]), 34);
        tick();
        drive(2'b00, 2'b00, 1, 1, 2'b00, 1'b0);
        chk("single_pop_count", int'(bus.count), 29);

        // Drain to one entry, then refill with a push while pops are blocked.
        do_reset();
        for (int r = 0; r < 15; r++) begin
            drive(2'b11, 2'b00, 1, 1, 2'b00, 1'b0);
            tick();
        end
        drive(2'b01, 2'b00, 1, 1, 2'b00, 1'b0);
        tick();
        drive(2'b11, 2'b01, 5, 1, 2'b00, 1'b0);
        chk("drain_count", int'(bus.count), 1);
        chk("drain_pop_ready", int'(bus.pop_ready), 0);
        tick();
        drive(2'b11, 2'b00, 1, 1, 2'b00, 1'b0);
        chk("refill_count", int'(bus.count), 2);
        chk("refill_pop_ready", int'(bus.pop_ready), 1);
        chk("refill_free_idx0", int'(bus.free_idx[0]), 63);
        chk("refill_free_idx1", int'(bus.free_idx[1]), 5);

        // Allocate six, commit two of them in the flush cycle, roll back.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            drive(2'b11, 2'b00, 1, 1, 2'b00, 1'b0);
            tick();
        end
        drive(2'b00, 2'b00, 1, 1, 2'b00, 1'b0);
        chk("alloc6_count", int'(bus.count), 26);
        drive(2'b11, 2'b11, 7, 9, 2'b11, 1'b1);
        chk("flush_pop_ready", int'(bus.pop_ready), 0);
        tick();
        drive(2'b11, 2'b00, 1, 1, 2'b00, 1'b0);
        chk("post_flush_count", int'(bus.count), 32);
        chk("post_flush_free_idx0", int'(bus.free_idx[0]), 34);
        chk("post_flush_free_idx1", int'(bus.free_idx[1]), 35);

        // Wrap: offset by one so a dual pop straddles slot N-1 and slot 0.
        do_reset();
        drive(2'b01, 2'b00, 1, 1, 2'b00, 1'b0);
        chk("wrap_pre_free_idx0", int'(bus.free_idx[0]), 32);
        tick();
        drive(2'b00, 2'b01, 32, 1, 2'b01, 1'b0);
        tick();
        for (int r = 0; r < 40; r++) begin
            e0 = 32 + ((1 + 2 * r) % 32);
            e1 = 32 + ((2 + 2 * r) % 32);
            drive(2'b11, 2'b00, 1, 1, 2'b00, 1'b0);
            chk("wrap_count_full", int'(bus.count), 32);
            chk("wrap_free_idx0", int'(bus.free_idx[0]), e0);
            chk("wrap_free_idx1", int'(bus.free_idx[1]), e1);
            tick();
            drive(2'b00, 2'b11, e0, e1, 2'b11, 1'b0);
            chk("wrap_count_out", int'(bus.count), 30);
            tick();
        end
        drive(2'b00, 2'b00, 1, 1, 2'b00, 1'b0);
        chk("wrap_end_count", int'(bus.count), 32);

        // Reset in the middle of traffic overrides flush, push and pop.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            drive(2'b11, 2'b00, 1, 1, 2'b00, 1'b0);
            tick();
        end
        rst = 1'b0;
        drive(2'b11, 2'b11, 7, 9, 2'b11, 1'b1);
        tick();
        rst = 1'b1;
        drive(2'b11, 2'b00, 1, 1, 2'b00, 1'b0);
        chk("midrst_count", int'(bus.count), 32);
        chk("midrst_pop_ready", int'(bus.pop_ready), 1);
        chk("midrst_free_idx0", int'(bus.free_idx[0]), 32);
        chk("midrst_free_idx1", int'(bus.free_idx[1]), 33);
        drive(2'b00, 2'b00, 1, 1, 2'b00, 1'b0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/free_list_ctrl.md
Name: free_list_ctrl

Overview:
- Circular-buffer allocator for physical register indices, shared by the rename lanes of the decode stage and the ROB commit path.
- Decode lanes pop free destination registers, up to ID_WIDTH per cycle, all-or-nothing ready.
- ROB commit pushes back stale physical registers and reports which committed uops had allocated one.
- On backend flush the allocation head rolls back to the committed head, reclaiming every speculatively allocated register in one cycle.

Parameters:
- PRF_DEPTH, 64, number of physical registers; PRF_IDX = $clog2(PRF_DEPTH).
- ARF_DEPTH, 32, number of architectural registers; phys 0..ARF_DEPTH-1 are mapped at reset.
- ID_WIDTH, 2, rename (pop) lanes.
- CM_WIDTH, 2, commit (push) lanes.
- Derived: N = PRF_DEPTH-ARF_DEPTH (32) entries. PTR = $clog2(N)+1-bit pointers; MSB is the wrap bit.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset; state resets on a posedge where rst==0.
- pop_valid  in  ID_WIDTH  lane i wants a destination register (rd_arch!=0).
- pop_ready  out  1  all lanes may pop this cycle.
- free_idx  out  ID_WIDTH x PRF_IDX  register handed to lane i, combinational.
- push_valid  in  CM_WIDTH  commit lane i returns a stale register.
- push_idx  in  CM_WIDTH x PRF_IDX  stale register being returned.
- commit_alloc  in  CM_WIDTH  committing uop on lane i had allocated a register.
- flush  in  1  backend flush; roll back speculative allocations.
- count  out  PTR  registered number of free entries.

Behaviour:
- Reset (rst==0 at posedge):
  - mem[k] = ARF_DEPTH+k for k=0..N-1.
  - head=0, tail=N (wrap bit set, index 0), cm_head=0.
  - count=N; pop_ready=1 after reset.
- count = tail-head, modulo 2^PTR.
- pop_ready = (count >= ID_WIDTH) && !flush. Combinational from registered count and flush only; it never depends on pop_valid.
- free_idx[i] = mem[(head + popcount(pop_valid[0..i-1])) mod N].
  - pop_valid=2'b10 gives free_idx[1]=mem[head].
  - free_idx is valid whenever pop_ready=1, regardless of that lane's own pop_valid.
- Pop fires when pop_ready && any pop_valid. head += popcount(pop_valid) at the next edge. pop_valid while !pop_ready is ignored and head is unchanged.
- Push:
  - Valid lanes are compacted in lane order.
  - mem[(tail+j) mod N] = push_idx of the j-th valid lane.
  - tail += popcount(push_valid).
  - Pushed entries are not visible to free_idx until the next cycle (no bypass).
  - Pop and push in the same cycle are both applied; count_next = count - pops + pushes.
- Commit tracking: cm_head += popcount(commit_alloc) every cycle, including flush cycles.
- Flush:
  - head <= cm_head + popcount(commit_alloc); pops are blocked (pop_ready=0).
  - Pushes and commit_alloc in the flush cycle are still applied.
  - Next-cycle count = tail_next - head_next.
- Wrap-around: pointer indices are taken modulo N, and the wrap bit toggles on index overflow. For example, with head index N-1 and a dual pop, the lanes read mem[N-1] and mem[0].
- Illegal inputs, each checked by an assertion; the RTL does not guard them:
  - push with count_next > N.
  - push_idx==0.
  - cm_head advancing past head.
  - popcount(commit_alloc) > popcount(push_valid) on the same cycle.
- Reset mid-operation: reset wins over flush, pop and push in the same cycle. All pointers and mem return to reset values.

Test Plan:
- Reset (rst=0 one cycle) -> count=32, pop_ready=1, free_idx[0]=32, free_idx[1]=33.
- Dual pop pop_valid=11, then single pop pop_valid=10 -> cycle 1 lanes get 32 and 33. Cycle 2 free_idx[1]=34. count goes 32→30→29.
- Drain to count=1 -> pop_ready=0. A push of idx 5 that cycle gives count=2 and pop_ready=1 next cycle, with the entry read at mem[head] order intact.
- Allocate 6 with commit_alloc on 2 of them, then flush with push_valid=11 (idx 7, 9) -> head=cm_head=2; count=32-2+2=32; pop_ready=0 during the flush cycle.
- Wrap: 40 alloc/free rounds of 2 -> head index crosses N-1→0, free_idx sequence continues with the pushed values, and count never exceeds 32.
- rst=0 asserted mid-burst with flush=1 and push_valid=11 -> all state returns to the reset image; count=32, free_idx[0]=32.
